hypot_iter: RTL and testbench

Parametrised, multi-cycle magnitude unit. Computes floor(sqrt(x² + y²)), or the raw sum of squares, for two unsigned W-bit operands. It uses only shift-add squaring and a digit-by-digit restoring square root, with no `*` operator and no combinational loops over the operand width. Unlike the earlier single-cycle add-on, it trades latency for area, adds a valid/ready handshake on both sides, and is width-generic. It sits between operand registers fed from `ui_in`/`uio_in` and the `uo_out` result path.

---
 rtl/hypot_iter_if.sv | 29 ++
 rtl/hypot_iter.sv | 169 ++++++++++++++++
 tb/tb_hypot_iter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/hypot_iter_if.sv
// hypot_iter_if: operand / result handshake bundle for hypot_iter.
//   in_valid/in_ready : operand pair offer / unit idle
//   x, y, mode        : unsigned operands, 0 = magnitude, 1 = sum of squares
//   out_valid/out_ready : result offer / consumer take
//   sumsq, mag        : x^2 + y^2 (2W+1 bits), floor(sqrt(sumsq)) (W+1 bits)
// master = producer of operands and consumer of results; slave = hypot_iter.
interface hypot_iter_if #(
  parameter int W = 8
) ();
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W:0]   sumsq;
  logic [W:0]     mag;

  modport master (
    output in_valid, x, y, mode, out_ready,
    input  in_ready, out_valid, sumsq, mag
  );

  modport slave (
    input  in_valid, x, y, mode, out_ready,
    output in_ready, out_valid, sumsq, mag
  );
endinterface

// File: rtl/hypot_iter.sv
// hypot_iter: multi-cycle magnitude unit, floor(sqrt(x^2 + y^2)) or x^2 + y^2.
// Squares are built by shift-add (one multiplier bit per cycle, LSB first),
// the root by a restoring digit-by-digit square root (one bit per cycle).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : hypot_iter_if.slave handshake bundle (operands in, results out)
module hypot_iter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  hypot_iter_if.slave  bus
);

  localparam int CW = $clog2(W + 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQX  = 3'd1,
    S_SQY  = 3'd2,
    S_ROOT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [W-1:0]     r_y;
  logic             r_mode;
  logic [W-1:0]     r_mplier;
  logic [2*W-1:0]   r_mcand;
  logic [2*W:0]     r_acc;
  logic [2*W+1:0]   r_rad;
  logic [W+1:0]     r_rem;
  logic [W:0]       r_root;
  logic             r_out_valid;
  logic [2*W:0]     r_sumsq;
  logic [W:0]       r_mag;

  logic [2*W:0]     w_acc_next;
  logic [W+4:0]     w_trial;
  logic [W+1:0]     w_rem_next;
  logic [W:0]       w_root_next;
  logic             w_cnt_zero;

  // Next-step datapath: shift-add partial product and one root trial.
  always_comb begin
    w_acc_next  = r_acc;
    w_rem_next  = r_rem;
    w_root_next = r_root;
    if (r_mplier[0]) begin
      w_acc_next = r_acc + {1'b0, r_mcand};
    end else begin
      w_acc_next = r_acc;
    end
    // Top bit of the W+5 bit difference is the borrow: set means trial < 0.
    w_trial = {1'b0, r_rem, r_rad[2*W+1:2*W]} - {2'b00, r_root, 2'b01};
    if (!w_trial[W+4]) begin
      w_rem_next  = w_trial[W+1:0];
      w_root_next = {r_root[W-1:0], 1'b1};
    end else begin
      // Restore: keep the shifted remainder; it stays below 2*root.
      w_rem_next  = {r_rem[W-1:0], r_rad[2*W+1:2*W]};
      w_root_next = {r_root[W-1:0], 1'b0};
    end
    w_cnt_zero = (r_cnt == {CW{1'b0}});
  end

  // Control FSM plus iterative datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CW{1'b0}};
      r_y         <= {W{1'b0}};
      r_mode      <= 1'b0;
      r_mplier    <= {W{1'b0}};
      r_mcand     <= {(2*W){1'b0}};
      r_acc       <= {(2*W+1){1'b0}};
      r_rad       <= {(2*W+2){1'b0}};
      r_rem       <= {(W+2){1'b0}};
      r_root      <= {(W+1){1'b0}};
      r_out_valid <= 1'b0;
      r_sumsq     <= {(2*W+1){1'b0}};
      r_mag       <= {(W+1){1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_y      <= bus.y;
            r_mode   <= bus.mode;
            r_mplier <= bus.x;
            r_mcand  <= {{W{1'b0}}, bus.x};
            r_acc    <= {(2*W+1){1'b0}};
            r_cnt    <= CW'(W - 1);
            r_state  <= S_SQX;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_SQX: begin
          r_acc <= w_acc_next;
          if (w_cnt_zero) begin
            // x^2 complete; reload the shifter with y, keep accumulating.
            r_mplier <= r_y;
            r_mcand  <= {{W{1'b0}}, r_y};
            r_cnt    <= CW'(W - 1);
            r_state  <= S_SQY;
          end else begin
            r_mplier <= r_mplier >> 1;
            r_mcand  <= r_mcand << 1;
            r_cnt    <= r_cnt - CW'(1);
          end
        end
        S_SQY: begin
          r_acc <= w_acc_next;
          if (w_cnt_zero) begin
            if (r_mode) begin
              r_sumsq     <= w_acc_next;
              r_mag       <= {(W+1){1'b0}};
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_rad   <= {1'b0, w_acc_next};
              r_rem   <= {(W+2){1'b0}};
              r_root  <= {(W+1){1'b0}};
              r_cnt   <= CW'(W);
              r_state <= S_ROOT;
            end
          end else begin
            r_mplier <= r_mplier >> 1;
            r_mcand  <= r_mcand << 1;
            r_cnt    <= r_cnt - CW'(1);
          end
        end
        S_ROOT: begin
          r_rem  <= w_rem_next;
          r_root <= w_root_next;
          r_rad  <= {r_rad[2*W-1:0], 2'b00};
          if (w_cnt_zero) begin
            r_sumsq     <= r_acc;
            r_mag       <= w_root_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state     <= S_DONE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.sumsq     = r_sumsq;
  assign bus.mag       = r_mag;

endmodule

// File: tb/tb_hypot_iter.sv
// tb_hypot_iter: directed and randomized checks of hypot_iter at W = 4, 8, 12.
// One operand/handshake driver is steered to the selected instance; results
// are compared with an integer-arithmetic reference (x*x + y*y, exact isqrt).
module tb_hypot_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic [15:0] tb_x;
  logic [15:0] tb_y;
  logic        tb_mode;
  logic        tb_in_valid;
  logic        tb_out_ready;

  logic        m_in_ready;
  logic        m_out_valid;
  logic [32:0] m_sumsq;
  logic [16:0] m_mag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hypot_iter_if #(.W(4))  if4  ();
  hypot_iter_if #(.W(8))  if8  ();
  hypot_iter_if #(.W(12)) if12 ();

  hypot_iter #(.W(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  hypot_iter #(.W(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  hypot_iter #(.W(12)) u_dut12 (.clk(clk), .rst_n(rst_n), .bus(if12.slave));

  assign if4.in_valid   = tb_in_valid && (sel == 2'd0);
  assign if4.x          = tb_x[3:0];
  assign if4.y          = tb_y[3:0];
  assign if4.mode       = tb_mode;
  assign if4.out_ready  = tb_out_ready;
  assign if8.in_valid   = tb_in_valid && (sel == 2'd1);
  assign if8.x          = tb_x[7:0];
  assign if8.y          = tb_y[7:0];
  assign if8.mode       = tb_mode;
  assign if8.out_ready  = tb_out_ready;
  assign if12.in_valid  = tb_in_valid && (sel == 2'd2);
  assign if12.x         = tb_x[11:0];
  assign if12.y         = tb_y[11:0];
  assign if12.mode      = tb_mode;
  assign if12.out_ready = tb_out_ready;

  // Route the selected instance's outputs to the common observation signals.
  always_comb begin
    m_in_ready  = 1'b0;
    m_out_valid = 1'b0;
    m_sumsq     = 33'd0;
    m_mag       = 17'd0;
    case (sel)
      2'd0: begin
        m_in_ready = if4.in_ready; m_out_valid = if4.out_valid;
        m_sumsq = 33'(if4.sumsq); m_mag = 17'(if4.mag);
      end
      2'd1: begin
        m_in_ready = if8.in_ready; m_out_valid = if8.out_valid;
        m_sumsq = 33'(if8.sumsq); m_mag = 17'(if8.mag);
      end
      2'd2: begin
        m_in_ready = if12.in_ready; m_out_valid = if12.out_valid;
        m_sumsq = 33'(if12.sumsq); m_mag = 17'(if12.mag);
      end
      default: begin
        m_in_ready = 1'b0;
      end
    endcase
  end

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  function automatic longint ref_sumsq(input longint a, input longint b);
    return a * a + b * b;
  endfunction

  function automatic longint ref_isqrt(input longint v);
    longint r;
    r = longint'($sqrt(real'(v)));
    while (r * r > v) r--;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // One full transaction on instance s, optional stall cycles before the pop.
  task automatic run_op(input logic [1:0] s, input logic [15:0] xv, input logic [15:0] yv,
                        input logic md, input int stall, input longint esum, input longint emag);
    int w;
    int n;
    w = 4 + 4 * int'(s);
    @(negedge clk);
    sel = s; tb_x = xv; tb_y = yv; tb_mode = md;
    tb_in_valid = 1'b1; tb_out_ready = (stall == 0);
    n = 0;
    while (!m_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready_idle", longint'(m_in_ready), 64'd1);
    @(posedge clk); #1;
    // Scramble inputs after the accepting edge: they must not matter.
    tb_in_valid = 1'b0; tb_x = 16'($urandom); tb_y = 16'($urandom); tb_mode = ~md;
    check_eq("in_ready_busy", longint'(m_in_ready), 64'd0);
    n = 0;
    while (!m_out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", longint'(n), md ? longint'(2 * w) : longint'(3 * w + 1));
    check_eq("sumsq", longint'(m_sumsq), esum);
    check_eq("mag", longint'(m_mag), emag);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      tb_in_valid = 1'b1; tb_x = 16'($urandom); tb_y = 16'($urandom);
      check_eq("stall_valid", longint'(m_out_valid), 64'd1);
      check_eq("stall_in_ready", longint'(m_in_ready), 64'd0);
      check_eq("stall_sumsq", longint'(m_sumsq), esum);
      check_eq("stall_mag", longint'(m_mag), emag);
    end
    if (stall > 0) begin
      @(negedge clk);
      tb_in_valid = 1'b0; tb_out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check_eq("pop_valid", longint'(m_out_valid), 64'd0);
    check_eq("pop_in_ready", longint'(m_in_ready), 64'd1);
    check_eq("pop_sumsq_kept", longint'(m_sumsq), esum);
    check_eq("pop_mag_kept", longint'(m_mag), emag);
    tb_out_ready = 1'b1;
  endtask

  task automatic run_rand(input logic [1:0] s, input int count);
    int w;
    logic [15:0] xv;
    logic [15:0] yv;
    logic md;
    longint sq;
    w = 4 + 4 * int'(s);
    for (int i = 0; i < count; i++) begin
      xv = 16'($urandom_range(0, (1 << w) - 1));
      yv = 16'($urandom_range(0, (1 << w) - 1));
      if (i % 10 == 0) xv = 16'((1 << w) - 1);
      md = 1'($urandom_range(0, 1));
      sq = ref_sumsq(longint'(xv), longint'(yv));
      run_op(s, xv, yv, md, (i % 7 == 0) ? 2 : 0, sq, md ? 64'd0 : ref_isqrt(sq));
    end
  endtask

  initial begin
    rst_n = 1'b0; sel = 2'd1; tb_x = 16'd0; tb_y = 16'd0; tb_mode = 1'b0;
    tb_in_valid = 1'b0; tb_out_ready = 1'b1;
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check_eq("rst_in_ready", longint'(m_in_ready), 64'd1);
      check_eq("rst_out_valid", longint'(m_out_valid), 64'd0);
      check_eq("rst_sumsq", longint'(m_sumsq), 64'd0);
      check_eq("rst_mag", longint'(m_mag), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'd1, 16'd3, 16'd4, 1'b0, 0, 64'd25, 64'd5);
    run_op(2'd1, 16'd255, 16'd255, 1'b0, 0, 64'd130050, 64'd360);
    run_op(2'd1, 16'd0, 16'd0, 1'b0, 0, 64'd0, 64'd0);
    run_op(2'd1, 16'd12, 16'd5, 1'b1, 0, 64'd169, 64'd0);
    run_op(2'd1, 16'd6, 16'd8, 1'b0, 10, 64'd100, 64'd10);
    run_op(2'd1, 16'd5, 16'd12, 1'b0, 0, 64'd169, 64'd13);
    run_op(2'd0, 16'd15, 16'd15, 1'b0, 0, 64'd450, 64'd21);

    // Reset while the root phase is in flight (edge k+20 of a W=8 op).
    @(negedge clk);
    sel = 2'd1; tb_x = 16'd200; tb_y = 16'd100; tb_mode = 1'b0; tb_in_valid = 1'b1;
    @(posedge clk); #1;
    tb_in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("pre_rst_busy", longint'(m_out_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready", longint'(m_in_ready), 64'd1);
    check_eq("midrst_out_valid", longint'(m_out_valid), 64'd0);
    check_eq("midrst_sumsq", longint'(m_sumsq), 64'd0);
    check_eq("midrst_mag", longint'(m_mag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'd1, 16'd3, 16'd4, 1'b0, 0, 64'd25, 64'd5);

    run_rand(2'd0, 150);
    run_rand(2'd1, 150);
    run_rand(2'd2, 150);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
